pipe_stage_reg: RTL

Parametrised inter-stage pipeline register, the successor to the fixed 32-bit F/D latch. It carries instruction, PC, exception code, branch-delay flag and a valid bit between two stages. It supports stall (hold), flush (bubble insertion) and bubble canonicalisation, and keeps saturating stall and flush event counters for performance debug. Instantiated between F/D, D/E, E/M and M/W; the hazard unit drives en/flush, and the CP0 flush path drives flush on exception or eret.

---
 rtl/pipe_stage_reg.sv | 102 ++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/flush/bubble canonicalisation and saturating stall/flush counters.
// One-cycle latency when en=1; en=0 holds the payload, and flush overrides a hold to insert a bubble.
module pipe_stage_reg #(
  parameter int          IW       = 32,
  parameter int          PW       = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          EW       = 5,
  parameter int          CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          flush,
  input  logic          cnt_clr,
  input  logic [IW-1:0] instr_in,
  input  logic [PW-1:0] pc_in,
  input  logic [EW-1:0] exc_in,
  input  logic          bd_in,
  input  logic          valid_in,
  output logic [IW-1:0] instr_out,
  output logic [PW-1:0] pc_out,
  output logic [EW-1:0] exc_out,
  output logic          bd_out,
  output logic          valid_out,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  localparam logic [PW-1:0] RESET_PC_W = PW'(RESET_PC);

  logic [IW-1:0] instr_q, instr_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [EW-1:0] exc_q, exc_d;
  logic          bd_q, bd_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] stall_q, stall_d;
  logic [CW-1:0] flush_q, flush_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    valid_d = valid_q;
    // A flush and a load both take the upstream PC/bd; only a real
    // instruction that is loaded (not flushed) keeps instr/exc/valid.
    if (flush || en) begin
      pc_d    = pc_in;
      bd_d    = bd_in;
      instr_d = '0;
      exc_d   = '0;
      valid_d = 1'b0;
      if (!flush && valid_in) begin
        instr_d = instr_in;
        exc_d   = exc_in;
        valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (cnt_clr) begin
      stall_d = '0;
      flush_d = '0;
    end else if (flush) begin
      if (!(&flush_q)) flush_d = flush_q + CW'(1);
    end else if (!en) begin
      if (!(&stall_q)) stall_d = stall_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= RESET_PC_W;
      exc_q   <= '0;
      bd_q    <= 1'b0;
      valid_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign exc_out   = exc_q;
  assign bd_out    = bd_q;
  assign valid_out = valid_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
